// File: rtl/multi_player_score_engine_pkg.sv
// Shared definitions for the multi-player score engine.
// Optional feature macro: DOUBLE_POINTS_EN (see multi_player_score_engine.sv).
// Contents: house codes, default point values, double-points window constants,
//           BCD converter FSM state encoding, max_score / pow10 helpers.
package multi_player_score_engine_pkg;

    typedef enum logic [1:0] {
        HouseG = 2'b00,
        HouseS = 2'b01,
        HouseH = 2'b10,
        HouseR = 2'b11
    } house_e;

    localparam int unsigned NumHouses         = 4;
    localparam int unsigned DefHitPoints      = 10;
    localparam int unsigned DefSnitchPoints   = 150;
    localparam int unsigned DefTurnerPoints   = 50;

    // Double-points window length in cycles and its counter width.
    localparam int unsigned DoubleWindow      = 1000;
    localparam int unsigned WindowW           = 10;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } bcd_state_e;

    // Largest value representable in an unsigned accumulator of the given width.
    function automatic logic [63:0] max_score(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_player_score_engine_bcd_serial_converter.sv
// Serial double-dabble binary-to-BCD converter.
// Ports:
//   clock_i, reset_i  clock, asynchronous active-high reset (aborts a conversion)
//   start_i           load bin_i and clear the BCD register; shifting starts next cycle
//   bin_i             binary value to convert
//   done_o            high during the final shift cycle; bcd_o holds the result from the
//                     following cycle until the next start_i
//   bcd_o             BCD result, ones digit in the LSB nibble (bits beyond NUM_DIGITS dropped)
module bcd_serial_converter
    import multi_player_score_engine_pkg::*;
#(
    parameter int unsigned SCORE_W    = 16,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [SCORE_W-1:0]        bin_i,
    output logic                      done_o,
    output logic [NUM_DIGITS*4-1:0]   bcd_o
);

    localparam int unsigned BcdW = NUM_DIGITS * 4;
    localparam int unsigned CntW = $clog2(SCORE_W + 1);

    logic [SCORE_W-1:0] bin_q;
    logic [BcdW-1:0]    bcd_q;
    logic [BcdW-1:0]    adj;
    logic [CntW-1:0]    cnt_q;
    logic               active_q;
    logic               last_shift;

    // Add-3 correction on every nibble >= 5 ahead of the shift.
    always_comb begin
        adj = bcd_q;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (bcd_q[d*4 +: 4] >= 4'd5) begin
                adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
            end
        end
    end

    assign last_shift = active_q && (cnt_q == CntW'(SCORE_W - 1));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            bin_q    <= bin_i;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            bcd_q <= {adj[BcdW-2:0], bin_q[SCORE_W-1]};
            bin_q <= {bin_q[SCORE_W-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
            if (last_shift) begin
                active_q <= 1'b0;
            end
        end
    end

    assign done_o = last_shift;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/multi_player_score_engine.sv
// N-player scoring core: IR hit detection, saturating per-player and per-house totals,
// round-robin registered BCD digits for the VGA path.
// Optional feature macro: DOUBLE_POINTS_EN -- time-turner pulses open a per-player window
// (DoubleWindow active cycles) of doubled hit points instead of awarding TURNER_POINTS.
// Ports:
//   clock_i, reset_i     clock, asynchronous active-high reset
//   game_active_i        scoring enable
//   clear_scores_i       synchronous clear of all totals (wins over increments)
//   ir_in_i              IR readings, player p at [p*IR_W +: IR_W]
//   house_sel_i          per-player house code (house_e)
//   snitch_caught_i      per-player snitch bonus pulses
//   turner_caught_i      per-player time-turner pulses
//   player_score_o       per-player totals
//   house_score_o        G,S,H,R totals at slots 0..3
//   digits_out_o         BCD digits per player, ones digit in the LSB nibble
//   digits_valid_o       one-cycle pulse when a player's digits are rewritten
//   busy_o               converter in LOAD or SHIFT
module multi_player_score_engine
    import multi_player_score_engine_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned IR_W          = 16,
    parameter int unsigned SCORE_W       = 16,
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned HIT_POINTS    = DefHitPoints,
    parameter int unsigned SNITCH_POINTS = DefSnitchPoints,
    parameter int unsigned TURNER_POINTS = DefTurnerPoints
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               game_active_i,
    input  logic                               clear_scores_i,
    input  logic [NUM_PLAYERS*IR_W-1:0]        ir_in_i,
    input  logic [NUM_PLAYERS*2-1:0]           house_sel_i,
    input  logic [NUM_PLAYERS-1:0]             snitch_caught_i,
    input  logic [NUM_PLAYERS-1:0]             turner_caught_i,
    output logic [NUM_PLAYERS*SCORE_W-1:0]     player_score_o,
    output logic [NumHouses*SCORE_W-1:0]       house_score_o,
    output logic [NUM_PLAYERS*NUM_DIGITS*4-1:0] digits_out_o,
    output logic [NUM_PLAYERS-1:0]             digits_valid_o,
    output logic                               busy_o
);

    localparam int unsigned BcdW  = NUM_DIGITS * 4;
    localparam int unsigned PtrW  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic [63:0] MaxScore   = max_score(SCORE_W);
    localparam logic [63:0] ClampLimit = pow10(NUM_DIGITS);

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [31:0] b);
        logic [63:0] s;
        s = {{(64-SCORE_W){1'b0}}, a} + {32'd0, b};
        return (s > MaxScore) ? MaxScore[SCORE_W-1:0] : s[SCORE_W-1:0];
    endfunction

    // ---------------- scoring datapath ----------------
    logic [NUM_PLAYERS-1:0] ir_nz, ir_nz_q, hit;
    logic [31:0]            hit_pts [NUM_PLAYERS];
    logic [31:0]            inc     [NUM_PLAYERS];
    logic [31:0]            hsum    [NumHouses];
    logic [SCORE_W-1:0]     player_q [NUM_PLAYERS];
    logic [SCORE_W-1:0]     player_d [NUM_PLAYERS];
    logic [SCORE_W-1:0]     house_q  [NumHouses];
    logic [SCORE_W-1:0]     house_d  [NumHouses];

`ifdef DOUBLE_POINTS_EN
    logic [WindowW-1:0] win_q [NUM_PLAYERS];
    logic [WindowW-1:0] win_d [NUM_PLAYERS];

    always_comb begin
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            win_d[p] = win_q[p];
            if (clear_scores_i) begin
                win_d[p] = '0;
            end else if (turner_caught_i[p]) begin
                win_d[p] = WindowW'(DoubleWindow);
            end else if (game_active_i && (win_q[p] != '0)) begin
                win_d[p] = win_q[p] - 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) win_q[p] <= '0;
        end else begin
            win_q <= win_d;
        end
    end
`endif

    always_comb begin
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            ir_nz[p] = |ir_in_i[p*IR_W +: IR_W];
            hit[p]   = ir_nz[p] && !ir_nz_q[p];
`ifdef DOUBLE_POINTS_EN
            hit_pts[p] = (win_q[p] != '0) ? 2 * HIT_POINTS : HIT_POINTS;
            inc[p] = (hit[p] ? hit_pts[p] : 32'd0)
                   + (snitch_caught_i[p] ? SNITCH_POINTS : 32'd0);
`else
            hit_pts[p] = HIT_POINTS;
            inc[p] = (hit[p] ? hit_pts[p] : 32'd0)
                   + (snitch_caught_i[p] ? SNITCH_POINTS : 32'd0)
                   + (turner_caught_i[p] ? TURNER_POINTS : 32'd0);
`endif
        end
    end

    // Every player in a house contributes in the same cycle.
    always_comb begin
        for (int unsigned h = 0; h < NumHouses; h++) begin
            hsum[h] = 32'd0;
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                if (house_sel_i[p*2 +: 2] == 2'(h)) begin
                    hsum[h] = hsum[h] + inc[p];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            player_d[p] = player_q[p];
            if (clear_scores_i)     player_d[p] = '0;
            else if (game_active_i) player_d[p] = sat_add(player_q[p], inc[p]);
        end
        for (int unsigned h = 0; h < NumHouses; h++) begin
            house_d[h] = house_q[h];
            if (clear_scores_i)     house_d[h] = '0;
            else if (game_active_i) house_d[h] = sat_add(house_q[h], hsum[h]);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ir_nz_q <= '0;
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) player_q[p] <= '0;
            for (int unsigned h = 0; h < NumHouses; h++) house_q[h] <= '0;
        end else begin
            ir_nz_q  <= ir_nz;
            player_q <= player_d;
            house_q  <= house_d;
        end
    end

    // ---------------- BCD conversion FSM ----------------
    bcd_state_e          state_q, state_d;
    logic [PtrW-1:0]     ptr_q;
    logic                clamp_q;
    logic [BcdW-1:0]     digits_q [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] valid_q;
    logic                conv_start, conv_done;
    logic [BcdW-1:0]     conv_bcd;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (conv_done) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        conv_start = (state_q == StLoad);
        busy_o     = (state_q == StLoad) || (state_q == StShift);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q   <= '0;
            clamp_q <= 1'b0;
            valid_q <= '0;
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) digits_q[p] <= '0;
        end else begin
            valid_q <= '0;
            if (state_q == StLoad) begin
                clamp_q <= ({{(64-SCORE_W){1'b0}}, player_q[ptr_q]} >= ClampLimit);
            end
            if (state_q == StDone) begin
                digits_q[ptr_q] <= clamp_q ? {NUM_DIGITS{4'h9}} : conv_bcd;
                valid_q[ptr_q]  <= 1'b1;
                ptr_q <= (ptr_q == PtrW'(NUM_PLAYERS - 1)) ? '0 : ptr_q + 1'b1;
            end
        end
    end

    bcd_serial_converter #(
        .SCORE_W    (SCORE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bcd (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .start_i (conv_start),
        .bin_i   (player_q[ptr_q]),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // ---------------- output packing ----------------
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pack_player
        assign player_score_o[p*SCORE_W +: SCORE_W] = player_q[p];
        assign digits_out_o[p*BcdW +: BcdW]         = digits_q[p];
    end
    for (genvar h = 0; h < NumHouses; h++) begin : g_pack_house
        assign house_score_o[h*SCORE_W +: SCORE_W] = house_q[h];
    end
    assign digits_valid_o = valid_q;

endmodule
